// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
// The LFSR is a 16-bit Galois right-shift register with taps 16'hB400.
package bounce_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR that advances only when en is high.
// A zero seed would lock the register at zero, so it is replaced by 1.
module lfsr16
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              GCLK,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge GCLK or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce waveform generator: on req, emits a tick-paced pseudo-random
// burst on sw_out, then holds the latched target for a settle window and pulses done.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int unsigned       TICK_DIV     = 100000,
  parameter int unsigned       BOUNCE_TICKS = 8,
  parameter int unsigned       SETTLE_TICKS = 20,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1
) (
  input  logic GCLK,
  input  logic rst_n,
  input  logic req,
  input  logic target,
  output logic sw_out,
  output logic busy,
  output logic done
);

  localparam int unsigned PW      = $clog2(TICK_DIV);
  localparam int unsigned CNT_MAX = (BOUNCE_TICKS > SETTLE_TICKS) ? BOUNCE_TICKS : SETTLE_TICKS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BOUNCE = CW'(BOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE_TICKS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            target_q, target_d;
  logic            sw_q, sw_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic              tick;
  logic              lfsr_en;
  logic [LFSR_W-1:0] lfsr_val;
  logic              unused_lfsr_hi;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .GCLK  (GCLK),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .value (lfsr_val)
  );

  // Only bit 0 feeds the waveform; the upper bits are pure LFSR state.
  assign unused_lfsr_hi = ^lfsr_val[LFSR_W-1:1];

  assign tick    = (presc_q == PRESC_LAST);
  assign lfsr_en = (state_q == BOUNCE) && tick;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sw_d     = sw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          target_d = target;
          presc_d  = '0;
          cnt_d    = CNT_BOUNCE;
          busy_d   = 1'b1;
          state_d  = BOUNCE;
        end
      end

      BOUNCE: begin
        if (tick) begin
          presc_d = '0;
          // The final bounce tick already lands on the clean level.
          if (cnt_q == CNT_ONE) begin
            sw_d    = target_q;
            cnt_d   = CNT_SETTLE;
            state_d = SETTLE;
          end else begin
            sw_d  = lfsr_val[0];
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      SETTLE: begin
        if (tick) begin
          presc_d = '0;
          if (cnt_q == CNT_ONE) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge GCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      target_q <= 1'b0;
      sw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sw_q     <= sw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sw_out = sw_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: the stimulus side predicts timed tick events
// per accepted request; a negedge monitor pops and compares them against the DUT.
module tb_bounce_gen;

  localparam int TD    = 4;
  localparam int BT    = 3;
  localparam int ST    = 2;
  localparam int BURST = (BT + ST) * TD;
  localparam logic [15:0] SEED = 16'hACE1;

  logic GCLK   = 1'b0;
  logic rst_n  = 1'b0;
  logic req    = 1'b0;
  logic target = 1'b0;
  logic sw_out;
  logic busy;
  logic done;

  bounce_gen #(
    .TICK_DIV    (TD),
    .BOUNCE_TICKS(BT),
    .SETTLE_TICKS(ST),
    .SEED        (SEED)
  ) dut (
    .GCLK  (GCLK),
    .rst_n (rst_n),
    .req   (req),
    .target(target),
    .sw_out(sw_out),
    .busy  (busy),
    .done  (done)
  );

  always #5 GCLK = ~GCLK;

  typedef struct {
    int cyc;
    bit sw;
    bit dn;
  } rec_t;

  rec_t exp_q[$];
  bit   obs[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          sw_hold = 1'b0;
  logic [15:0] m_lfsr = SEED;
  int          m_done_edge = -1000;

  always @(posedge GCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: at each negedge either a predicted tick is due, or outputs must hold.
  always @(negedge GCLK) begin : monitor
    rec_t r;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      r = exp_q.pop_front();
      check("sw_tick", sw_out, r.sw);
      check("done_tick", done, r.dn);
      obs.push_back(sw_out);
      sw_hold = r.sw;
    end else begin
      check("sw_hold", sw_out, sw_hold);
      check("done_quiet", done, 1'b0);
    end
    check("busy", busy, exp_q.size() > 0);
  end

  task automatic step();
    @(negedge GCLK);
    #1;
  endtask

  // Drive a 1-cycle req; predict the tick schedule if the block is idle at that edge.
  task automatic issue(input bit tgt);
    int   n;
    rec_t r;
    n      = cyc + 1;
    req    = 1'b1;
    target = tgt;
    if (n > m_done_edge) begin
      for (int k = 1; k <= BT + ST; k++) begin
        r.cyc = n + k * TD;
        r.dn  = (k == BT + ST);
        if (k < BT) r.sw = m_lfsr[0];
        else        r.sw = tgt;
        if (k <= BT) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        exp_q.push_back(r);
      end
      m_done_edge = n + BURST;
    end
    step();
    req = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    check("rst_sw", sw_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    exp_q.delete();
    m_lfsr      = SEED;
    m_done_edge = -1000;
    sw_hold     = 1'b0;
    repeat (hold) @(negedge GCLK);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      step();
      i++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle: %0d events still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic wait_until(input int c);
    int i;
    i = 0;
    while (cyc < c && i < 1000) begin
      step();
      i++;
    end
  endtask

  task automatic check_obs(input bit b0, input bit b1, input bit b2);
    total++;
    if (obs.size() < 3) begin
      bad++;
      $display("FAIL obs_count: got %0d ticks expected at least 3", obs.size());
    end else begin
      total--;
      check("seq_tick1", obs[0], b0);
      check("seq_tick2", obs[1], b1);
      check("seq_tick3", obs[2], b2);
    end
    obs.delete();
  endtask

  initial begin : stim
    int n;
    do_reset(3);
    repeat (20) step();

    obs.delete();
    issue(1'b1);
    wait_idle(200);
    check_obs(1'b1, 1'b0, 1'b1);

    issue(1'b0);
    wait_idle(200);
    check_obs(1'b0, 1'b0, 1'b0);

    issue(1'b1);
    n = cyc;
    wait_until(n + 4);
    issue(1'b0);
    wait_until(n + 14);
    issue(1'b0);
    wait_idle(200);
    obs.delete();

    issue(1'b1);
    n = cyc;
    wait_until(n + 8);
    do_reset(2);
    repeat (5) step();
    obs.delete();
    issue(1'b1);
    wait_idle(200);
    check_obs(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 5) == 0) begin
        issue(1'($urandom_range(0, 1)));
      end else begin
        step();
      end
    end
    wait_idle(200);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
